// File: rtl/ex_fwd_hazard_alu_pkg.sv
// Shared constants for the EX-stage forwarding/hazard/ALU slice.
// Opcodes, forwarding-select codes, widths and the ALU flag bundle.
package ex_fwd_hazard_alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int OP_W   = 5;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_NOTA  = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_PASSB = 5'b01010;
  localparam logic [4:0] OP_PASSA = 5'b01011;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
  } aluFlags_t;

endpackage

// File: rtl/ex_fwd_hazard_alu_alu.sv
// Combinational ALU core (alu_core) for the EX stage.
// Carry is add carry-out or subtract borrow; overflow only for add/sub.
module alu_core
  import ex_fwd_hazard_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              carry
);

  logic [DATA_W:0]    sum;
  logic [DATA_W:0]    diff;
  logic [SHAMT_W-1:0] shamt;
  logic               lessThan;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHAMT_W-1:0];
  assign lessThan = $signed(a) < $signed(b);

  // Result and status flag selection by opcode
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                   (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        result   = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                   (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOTA:  result = ~a;
      OP_SLL:   result = a << shamt;
      OP_SRL:   result = a >> shamt;
      OP_SRA:   result = $signed(a) >>> shamt;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, lessThan};
      OP_PASSB: result = b;
      OP_PASSA: result = a;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_fwd_hazard_alu.sv
// EX stage: operand forwarding, load-use/branch hazard control, ALU.
// Flag register is built only when ULA_FLAGS_REG_EN is defined.
module ex_fwd_hazard_alu
  import ex_fwd_hazard_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OP_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_ex_registerA,
  input  logic [REG_AW-1:0] id_ex_registerB,
  input  logic [DATA_W-1:0] id_ex_dataA,
  input  logic [DATA_W-1:0] id_ex_dataB,
  input  logic [DATA_W-1:0] id_ex_extended,
  input  logic              id_ex_ALUSrc,
  input  logic [OP_W-1:0]   id_ex_ALUOp,
  input  logic              ex_mem_regWrite,
  input  logic [REG_AW-1:0] ex_mem_registerRD,
  input  logic [DATA_W-1:0] ex_mem_ALUResult,
  input  logic              mem_wb_regWrite,
  input  logic [REG_AW-1:0] mem_wb_registerRD,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              id_ex_memRead,
  input  logic [REG_AW-1:0] id_ex_registerRD,
  input  logic [REG_AW-1:0] if_id_registerA,
  input  logic [REG_AW-1:0] if_id_registerB,
  input  logic              branch,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic [DATA_W-1:0] ALUResult,
  output logic              zero,
  output logic              overflow,
  output logic              carry,
  output logic [2:0]        flags,
  output logic              enablePC,
  output logic              muxSelector
);

  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] operandB;
  logic              loadUse;

  // Forwarding select: youngest producer (EX/MEM) wins, reg 0 included
  always_comb begin
    forwardA = FWD_REG;
    forwardB = FWD_REG;
    if (ex_mem_regWrite && ex_mem_registerRD == id_ex_registerA)
      forwardA = FWD_EXMEM;
    else if (mem_wb_regWrite && mem_wb_registerRD == id_ex_registerA)
      forwardA = FWD_WB;
    if (ex_mem_regWrite && ex_mem_registerRD == id_ex_registerB)
      forwardB = FWD_EXMEM;
    else if (mem_wb_regWrite && mem_wb_registerRD == id_ex_registerB)
      forwardB = FWD_WB;
  end

  // Operand muxes; immediate overrides any forwarding on B
  always_comb begin
    operandA = id_ex_dataA;
    operandB = id_ex_dataB;
    case (forwardA)
      FWD_WB:    operandA = wb_data;
      FWD_EXMEM: operandA = ex_mem_ALUResult;
      default:   operandA = id_ex_dataA;
    endcase
    case (forwardB)
      FWD_WB:    operandB = wb_data;
      FWD_EXMEM: operandB = ex_mem_ALUResult;
      default:   operandB = id_ex_dataB;
    endcase
    if (id_ex_ALUSrc)
      operandB = id_ex_extended;
  end

  assign loadUse = id_ex_memRead &&
                   (id_ex_registerRD == if_id_registerA ||
                    id_ex_registerRD == if_id_registerB);

  // Hazard control: a taken branch flushes and beats a load-use stall
  always_comb begin
    enablePC    = 1'b1;
    muxSelector = 1'b0;
    if (branch) begin
      enablePC    = 1'b1;
      muxSelector = 1'b1;
    end else if (loadUse) begin
      enablePC    = 1'b0;
      muxSelector = 1'b1;
    end
  end

  alu_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a        (operandA),
    .b        (operandB),
    .op       (id_ex_ALUOp),
    .result   (ALUResult),
    .zero     (zero),
    .overflow (overflow),
    .carry    (carry)
  );

`ifdef ULA_FLAGS_REG_EN
  aluFlags_t flagsQ;

  // Capture ALU status every cycle; reset clears it
  always_ff @(posedge clock) begin
    if (reset)
      flagsQ <= '0;
    else
      flagsQ <= '{zero: zero, overflow: overflow, carry: carry};
  end

  assign flags = flagsQ;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_ex_fwd_hazard_alu.sv
// Directed-vector scoreboard bench for ex_fwd_hazard_alu.
// Driver queues hand-computed results; monitor checks at negedge.
module tb_ex_fwd_hazard_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  id_ex_registerA, id_ex_registerB;
  logic [31:0] id_ex_dataA, id_ex_dataB, id_ex_extended;
  logic        id_ex_ALUSrc;
  logic [4:0]  id_ex_ALUOp;
  logic        ex_mem_regWrite;
  logic [3:0]  ex_mem_registerRD;
  logic [31:0] ex_mem_ALUResult;
  logic        mem_wb_regWrite;
  logic [3:0]  mem_wb_registerRD;
  logic [31:0] wb_data;
  logic        id_ex_memRead;
  logic [3:0]  id_ex_registerRD, if_id_registerA, if_id_registerB;
  logic        branch;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] ALUResult;
  logic        zero, overflow, carry;
  logic [2:0]  flags;
  logic        enablePC, muxSelector;

  typedef struct {
    int          id;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] res;
    logic [2:0]  zoc;
    logic        en;
    logic        mux;
    logic [2:0]  flg;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic       prevRst = 1'b1;
  logic [2:0] prevZoc = 3'b000;

  ex_fwd_hazard_alu dut (
    .clock             (clock),
    .reset             (reset),
    .id_ex_registerA   (id_ex_registerA),
    .id_ex_registerB   (id_ex_registerB),
    .id_ex_dataA       (id_ex_dataA),
    .id_ex_dataB       (id_ex_dataB),
    .id_ex_extended    (id_ex_extended),
    .id_ex_ALUSrc      (id_ex_ALUSrc),
    .id_ex_ALUOp       (id_ex_ALUOp),
    .ex_mem_regWrite   (ex_mem_regWrite),
    .ex_mem_registerRD (ex_mem_registerRD),
    .ex_mem_ALUResult  (ex_mem_ALUResult),
    .mem_wb_regWrite   (mem_wb_regWrite),
    .mem_wb_registerRD (mem_wb_registerRD),
    .wb_data           (wb_data),
    .id_ex_memRead     (id_ex_memRead),
    .id_ex_registerRD  (id_ex_registerRD),
    .if_id_registerA   (if_id_registerA),
    .if_id_registerB   (if_id_registerB),
    .branch            (branch),
    .forwardA          (forwardA),
    .forwardB          (forwardB),
    .ALUResult         (ALUResult),
    .zero              (zero),
    .overflow          (overflow),
    .carry             (carry),
    .flags             (flags),
    .enablePC          (enablePC),
    .muxSelector       (muxSelector)
  );

  always #5 clock = ~clock;

  task automatic chk(input int id, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  // Monitor: combinational outputs and registered flags are checked mid-cycle
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "forwardA", 32'(forwardA), 32'(e.fa));
      chk(e.id, "forwardB", 32'(forwardB), 32'(e.fb));
      chk(e.id, "ALUResult", ALUResult, e.res);
      chk(e.id, "zoc", 32'({zero, overflow, carry}), 32'(e.zoc));
      chk(e.id, "enablePC", 32'(enablePC), 32'(e.en));
      chk(e.id, "muxSelector", 32'(muxSelector), 32'(e.mux));
      chk(e.id, "flags", 32'(flags), 32'(e.flg));
    end
  end

  task automatic clr();
    id_ex_registerA   = 4'd1;
    id_ex_registerB   = 4'd2;
    id_ex_dataA       = 32'h0;
    id_ex_dataB       = 32'h0;
    id_ex_extended    = 32'h0;
    id_ex_ALUSrc      = 1'b0;
    id_ex_ALUOp       = 5'b00000;
    ex_mem_regWrite   = 1'b0;
    ex_mem_registerRD = 4'd9;
    ex_mem_ALUResult  = 32'h0;
    mem_wb_regWrite   = 1'b0;
    mem_wb_registerRD = 4'd10;
    wb_data           = 32'h0;
    id_ex_memRead     = 1'b0;
    id_ex_registerRD  = 4'd0;
    if_id_registerA   = 4'd11;
    if_id_registerB   = 4'd12;
    branch            = 1'b0;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    clr();
    id_ex_ALUOp = op;
    id_ex_dataA = a;
    id_ex_dataB = b;
  endtask

  // Queue the expected response for the inputs just driven, hold one cycle
  task automatic issue(input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] res, input logic [2:0] zoc,
                       input logic en, input logic mux);
    exp_t e;
    e.id  = vectors;
    e.fa  = fa;
    e.fb  = fb;
    e.res = res;
    e.zoc = zoc;
    e.en  = en;
    e.mux = mux;
`ifdef ULA_FLAGS_REG_EN
    e.flg = prevRst ? 3'b000 : prevZoc;
`else
    e.flg = 3'b000;
`endif
    prevRst = reset;
    prevZoc = zoc;
    q.push_back(e);
    vectors++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    repeat (2) @(posedge clock);
    #1;
    // combinational path live during reset
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b0);
    reset = 1'b0;
    // EX/MEM beats MEM/WB on the same register
    clr();
    id_ex_registerA = 4'd3;
    ex_mem_regWrite = 1'b1; ex_mem_registerRD = 4'd3;
    ex_mem_ALUResult = 32'h100;
    mem_wb_regWrite = 1'b1; mem_wb_registerRD = 4'd3; wb_data = 32'h200;
    id_ex_dataA = 32'h300; id_ex_ALUOp = 5'b01011;
    issue(2'b10, 2'b00, 32'h100, 3'b000, 1'b1, 1'b0);
    // MEM/WB forwarding on B
    clr();
    mem_wb_regWrite = 1'b1; mem_wb_registerRD = 4'd2; wb_data = 32'h200;
    id_ex_dataB = 32'h55; id_ex_ALUOp = 5'b01010;
    issue(2'b00, 2'b01, 32'h200, 3'b000, 1'b1, 1'b0);
    // register 0 is forwardable from EX/MEM
    clr();
    id_ex_registerA = 4'd0; id_ex_registerB = 4'd0;
    ex_mem_regWrite = 1'b1; ex_mem_registerRD = 4'd0; ex_mem_ALUResult = 32'd7;
    mem_wb_regWrite = 1'b1; mem_wb_registerRD = 4'd0; wb_data = 32'd9;
    issue(2'b10, 2'b10, 32'd14, 3'b000, 1'b1, 1'b0);
    // EX/MEM not writing: falls back to MEM/WB
    clr();
    id_ex_registerA = 4'd0; id_ex_registerB = 4'd0;
    ex_mem_registerRD = 4'd0; ex_mem_ALUResult = 32'd7;
    mem_wb_regWrite = 1'b1; mem_wb_registerRD = 4'd0; wb_data = 32'd9;
    issue(2'b01, 2'b01, 32'd18, 3'b000, 1'b1, 1'b0);
    // ALU arithmetic boundaries
    alu(5'b00000, 32'h7FFFFFFF, 32'h1);
    issue(2'b00, 2'b00, 32'h80000000, 3'b010, 1'b1, 1'b0);
    alu(5'b00000, 32'hFFFFFFFF, 32'h1);
    issue(2'b00, 2'b00, 32'h0, 3'b101, 1'b1, 1'b0);
    alu(5'b00001, 32'd5, 32'd5);
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b0);
    alu(5'b00001, 32'd2, 32'd5);
    issue(2'b00, 2'b00, 32'hFFFFFFFD, 3'b001, 1'b1, 1'b0);
    alu(5'b00001, 32'h80000000, 32'h1);
    issue(2'b00, 2'b00, 32'h7FFFFFFF, 3'b010, 1'b1, 1'b0);
    // logic, shifts, compare, pass, illegal
    alu(5'b00010, 32'hF0F0F0F0, 32'hFF00FF00);
    issue(2'b00, 2'b00, 32'hF000F000, 3'b000, 1'b1, 1'b0);
    alu(5'b00011, 32'hF0F0F0F0, 32'h0F0F0000);
    issue(2'b00, 2'b00, 32'hFFFFF0F0, 3'b000, 1'b1, 1'b0);
    alu(5'b00100, 32'hA5A5A5A5, 32'hFFFFFFFF);
    issue(2'b00, 2'b00, 32'h5A5A5A5A, 3'b000, 1'b1, 1'b0);
    alu(5'b00101, 32'hFFFF0000, 32'h12345678);
    issue(2'b00, 2'b00, 32'h0000FFFF, 3'b000, 1'b1, 1'b0);
    alu(5'b00110, 32'h1, 32'h24);
    issue(2'b00, 2'b00, 32'h10, 3'b000, 1'b1, 1'b0);
    alu(5'b00111, 32'h80000000, 32'h4);
    issue(2'b00, 2'b00, 32'h08000000, 3'b000, 1'b1, 1'b0);
    alu(5'b01000, 32'h80000000, 32'h4);
    issue(2'b00, 2'b00, 32'hF8000000, 3'b000, 1'b1, 1'b0);
    alu(5'b01001, 32'hFFFFFFFF, 32'h1);
    issue(2'b00, 2'b00, 32'h1, 3'b000, 1'b1, 1'b0);
    alu(5'b01001, 32'h1, 32'hFFFFFFFF);
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b0);
    alu(5'b11111, 32'd5, 32'd5);
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b0);
    // immediate overrides EX/MEM forwarding on B
    clr();
    id_ex_registerB = 4'd3; id_ex_dataB = 32'h55;
    ex_mem_regWrite = 1'b1; ex_mem_registerRD = 4'd3;
    ex_mem_ALUResult = 32'h999;
    id_ex_ALUSrc = 1'b1; id_ex_extended = 32'h10; id_ex_ALUOp = 5'b01010;
    issue(2'b00, 2'b10, 32'h10, 3'b000, 1'b1, 1'b0);
    // hazard unit
    clr();
    id_ex_memRead = 1'b1; id_ex_registerRD = 4'd7; if_id_registerB = 4'd7;
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b0, 1'b1);
    branch = 1'b1;
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b1);
    clr();
    branch = 1'b1;
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b1);
    clr();
    id_ex_memRead = 1'b1; id_ex_registerRD = 4'd7; if_id_registerA = 4'd7;
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b0, 1'b1);
    clr();
    id_ex_registerRD = 4'd7; if_id_registerA = 4'd7;
    issue(2'b00, 2'b00, 32'h0, 3'b100, 1'b1, 1'b0);
    // flag register: overflow, reset edge, then tracking again
    alu(5'b00000, 32'h7FFFFFFF, 32'h1);
    issue(2'b00, 2'b00, 32'h80000000, 3'b010, 1'b1, 1'b0);
    reset = 1'b1;
    issue(2'b00, 2'b00, 32'h80000000, 3'b010, 1'b1, 1'b0);
    reset = 1'b0;
    issue(2'b00, 2'b00, 32'h80000000, 3'b010, 1'b1, 1'b0);
    issue(2'b00, 2'b00, 32'h80000000, 3'b010, 1'b1, 1'b0);
    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clock);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
